// File: rtl/reg_access_arb.sv
// reg_access_arb
// Arbitrates two requesters (A and B) onto a single external register file.
// Each accepted operation reads two registers (source and destination). It can
// also write new data into the destination after that read
// (read-then-write).
//
// Ports
//   clk, rst_n                     clock; synchronous active-low reset
//   a_req/b_req                    requester wants one operation
//   a_we/b_we                      operation also writes the destination
//   a_sr/a_dr, b_sr/b_dr           source / destination register indices
//   a_wdata/b_wdata                write data
//   a_gnt/b_gnt                    one-cycle grant (READ cycle, owner only)
//   a_done/b_done                  one-cycle completion (DONE cycle, owner only)
//   rdata_s/rdata_d                read data of the last completed READ
//   busy                           any state other than IDLE
//   rf_we, rf_sr, rf_dr, rf_i      register-file control
//                                  (the file writes on the falling edge)
//   rf_s, rf_d                     combinational register-file read ports
module reg_access_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_we,
    input  logic       b_we,
    input  logic [1:0] a_sr,
    input  logic [1:0] a_dr,
    input  logic [1:0] b_sr,
    input  logic [1:0] b_dr,
    input  logic [7:0] a_wdata,
    input  logic [7:0] b_wdata,
    output logic       a_gnt,
    output logic       b_gnt,
    output logic       a_done,
    output logic       b_done,
    output logic [7:0] rdata_s,
    output logic [7:0] rdata_d,
    output logic       busy,
    output logic       rf_we,
    output logic [1:0] rf_sr,
    output logic [1:0] rf_dr,
    output logic [7:0] rf_i,
    input  logic [7:0] rf_s,
    input  logic [7:0] rf_d
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       ptr_reg;        // side favoured on a tie: 0 = A, 1 = B
    logic       owner_reg;      // side that owns the current operation
    logic       we_reg;
    logic [1:0] sr_reg;
    logic [1:0] dr_reg;
    logic [7:0] wdata_reg;
    logic [7:0] rdata_s_reg;
    logic [7:0] rdata_d_reg;
    logic       accept;
    logic       pick_b;

    always_comb begin
        // B wins when alone, or on a tie when round-robin favours it.
        pick_b     = b_req && (!a_req || (RR_EN && ptr_reg));
        accept     = (state_reg == IDLE) && (a_req || b_req);
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = we_reg ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= 1'b0;
            owner_reg   <= 1'b0;
            we_reg      <= 1'b0;
            sr_reg      <= 2'd0;
            dr_reg      <= 2'd0;
            wdata_reg   <= 8'h00;
            rdata_s_reg <= 8'h00;
            rdata_d_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg <= pick_b;
                we_reg    <= pick_b ? b_we    : a_we;
                sr_reg    <= pick_b ? b_sr    : a_sr;
                dr_reg    <= pick_b ? b_dr    : a_dr;
                wdata_reg <= pick_b ? b_wdata : a_wdata;
                // Next tie goes to whoever lost this one.
                if (RR_EN) begin
                    ptr_reg <= ~pick_b;
                end
            end
            // Latched at the end of READ, before any write lands, so rdata_d
            // always reflects the destination's pre-write contents.
            if (state_reg == READ) begin
                rdata_s_reg <= rf_s;
                rdata_d_reg <= rf_d;
            end
        end
    end

    assign a_gnt   = (state_reg == READ) && !owner_reg;
    assign b_gnt   = (state_reg == READ) &&  owner_reg;
    assign a_done  = (state_reg == DONE) && !owner_reg;
    assign b_done  = (state_reg == DONE) &&  owner_reg;
    assign busy    = (state_reg != IDLE);
    assign rf_we   = (state_reg == WRITE);
    assign rf_sr   = sr_reg;
    assign rf_dr   = dr_reg;
    assign rf_i    = wdata_reg;
    assign rdata_s = rdata_s_reg;
    assign rdata_d = rdata_d_reg;

endmodule

// File: doc/reg_access_arb.md
REG_ACCESS_ARB -- requirements
Module: reg_access_arb

Interface
REQ-001 Parameter RR_EN, default 1, SHALL select round-robin arbitration (1) or fixed priority with A always winning (0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a_req, b_req  input  1 each  requester wants one register-file operation.
REQ-005 a_we, b_we  input  1 each  operation also writes (read-then-write) when 1; read-only when 0.
REQ-006 a_sr, a_dr, b_sr, b_dr  input  2 each  source and destination register indices.
REQ-007 a_wdata, b_wdata  input  8 each  write data.
REQ-008 a_gnt, b_gnt  output  1 each  one-cycle grant pulse.
REQ-009 a_done, b_done  output  1 each  one-cycle completion pulse.
REQ-010 rdata_s, rdata_d  output  8 each  captured register-file read data of the last completed operation.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 rf_we  output  1, rf_sr  output  2, rf_dr  output  2, rf_i  output  8  register-file control; the register file writes on the falling clock edge while rf_we=1.
REQ-013 rf_s, rf_d  input  8 each  combinational register-file read ports for rf_sr, rf_dr.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.
REQ-015 IDLE: at a rising edge with any req high, SHALL accept one requester, capture its we/sr/dr/wdata and owner, and go to READ; with no req, SHALL stay in IDLE.
REQ-016 Arbitration on simultaneous a_req and b_req: RR_EN=1 grants the side indicated by a priority pointer; RR_EN=0 grants A.
REQ-017 The priority pointer SHALL point to the non-granted side after every accept (RR_EN=1), and SHALL start at A.
REQ-018 x_gnt SHALL be high for exactly the READ cycle following the accept, and only for the owner.
REQ-019 Requesters hold req and fields stable until they see gnt, then drop req; fields are sampled only at the accept edge.
REQ-020 READ: rf_sr/rf_dr SHALL carry the captured indices; at the end of READ, rf_s/rf_d SHALL be latched into rdata_s/rdata_d; next state is WRITE if captured we=1, else DONE.
REQ-021 WRITE: rf_we=1 for exactly one cycle, with rf_dr=captured dr and rf_i=captured wdata; next state DONE.
REQ-022 rf_we SHALL be decoded from the registered state only and SHALL be 0 in IDLE, READ, DONE.
REQ-023 rdata_d for a write operation SHALL hold the pre-write value of the destination.
REQ-024 DONE: owner's x_done=1 for one cycle; rdata_s/rdata_d valid and held until the next READ completes; next state IDLE.
REQ-025 Latency accept-edge to done: 2 cycles read-only, 3 cycles with write; back-to-back accepts SHALL be at least 3 (read) / 4 (write) cycles apart.
REQ-026 Requests arriving while busy=1 SHALL be ignored until IDLE; no queueing.
REQ-027 rf_sr, rf_dr, rf_i SHALL hold their last captured values outside READ/WRITE.

Reset
REQ-028 With rst_n=0 at a rising edge: state IDLE, pointer=A, captured fields and rdata_s/rdata_d=8'h00; all gnt, done, rf_we, busy=0; rf_sr, rf_dr, rf_i=0.
REQ-029 Reset asserted in READ or WRITE SHALL abort the operation: no done pulse, rf_we=0 from the next cycle, pending write not repeated after release.

Verification
REQ-030 Read-only: model r1=8'hAA, r3=8'h07; a_req, a_sr=1, a_dr=3, a_we=0 -> a_gnt 1 cycle later, a_done 2 cycles after accept, rdata_s=8'hAA, rdata_d=8'h07, rf_we never high.
REQ-031 Write: b_req, b_dr=2, b_sr=2, b_wdata=8'h5C, b_we=1, r2=8'h00 -> rf_we one cycle, rdata_d=8'h00, b_done 3 cycles after accept, r2=8'h5C afterwards.
REQ-032 Contention, RR_EN=1: a_req and b_req held continuously for 4 operations -> grants A,B,A,B; with RR_EN=0 -> A every time B not alone.
REQ-033 Busy ignore: b_req rises in A's READ cycle -> not granted until IDLE, then granted; a_done before b_gnt.
REQ-034 Reset mid-WRITE: rst_n low during WRITE cycle -> no a_done, rf_we=0 next cycle, rdata 8'h00, busy=0, pointer=A.
